// File: rtl/demux_buf.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | demux_buf : 1-to-2**N valid/ready stream demultiplexer, 2-entry FIFO/chan  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module demux_buf #(
   parameter int WIDTH = 32,
   parameter int N     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [N-1:0]         in_sel,
   output logic [(2**N)-1:0]    out_valid,
   input  logic [(2**N)-1:0]    out_ready,
   output logic [WIDTH-1:0]     out_data  [2**N],
   output logic [1:0]           out_count [2**N]
);

   localparam int         c_num_ch = 2**N;
   localparam logic [1:0] c_full   = 2'd2;

   logic [WIDTH-1:0] r_head  [c_num_ch];
   logic [WIDTH-1:0] r_tail  [c_num_ch];
   logic [1:0]       r_count [c_num_ch];

   logic             w_in_ready;

   // Back-pressure looks only at the addressed channel's registered count.
   assign w_in_ready = (r_count[in_sel] != c_full);
   assign in_ready   = w_in_ready;

   generate
      for (genvar c = 0; c < c_num_ch; c++) begin : g_ch
         logic w_push;
         logic w_pop;

         assign w_push = in_valid && w_in_ready && (in_sel == N'(c));
         assign w_pop  = (r_count[c] != 2'd0) && out_ready[c];

         assign out_valid[c] = (r_count[c] != 2'd0);
         assign out_data[c]  = r_head[c];
         assign out_count[c] = r_count[c];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_head[c]  <= '0;
               r_tail[c]  <= '0;
               r_count[c] <= 2'd0;
            end else begin
               case (r_count[c])
                  2'd0: begin
                     if (w_push) begin
                        r_head[c] <= in_data;
                     end
                  end
                  2'd1: begin
                     if (w_push && w_pop) begin
                        r_head[c] <= in_data;
                     end else if (w_push) begin
                        r_tail[c] <= in_data;
                     end
                  end
                  default: begin
                     if (w_pop) begin
                        r_head[c] <= r_tail[c];
                     end
                  end
               endcase

               if (w_push && !w_pop) begin
                  r_count[c] <= r_count[c] + 2'd1;
               end else if (w_pop && !w_push) begin
                  r_count[c] <= r_count[c] - 2'd1;
               end
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire
